// File: rtl/circuito_sequencia_param.sv
// Sequence memory game core: walks a DEPTH-word ROM comparing one play per word.
// Optional play timeout is enabled by defining CIRCUITO_SEQUENCIA_TIMEOUT_EN.
module circuito_sequencia_param #(
    parameter int    DATA_W         = 4,
    parameter int    DEPTH          = 16,
    parameter string MEM_FILE       = "",
    parameter int    TIMEOUT_CYCLES = 5000,
    localparam int   ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic [DATA_W-1:0] chaves,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              db_igual,
    output logic              db_jogada,
    output logic              db_timeout,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [DATA_W-1:0] db_memoria,
    output logic [DATA_W-1:0] db_chaves,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h4,
        COMPARA    = 4'h5,
        PROXIMO    = 4'h6,
        FIM_ACERTO = 4'hA,
        FIM_ERRO   = 4'hE
    } estado_t;

    estado_t           estado;
    estado_t           estado_prox;
    logic [ADDR_W-1:0] contagem;
    logic [DATA_W-1:0] chaves_reg;
    logic [DATA_W-1:0] rom_dado;
    logic              jogada_ant;
    logic              pulso;
    logic              igual;
    logic              ultimo;
    logic              expirou;

    assign rom_dado = DATA_W'(contagem);

    assign igual  = (chaves_reg == rom_dado);
    assign ultimo = (contagem == ADDR_W'(DEPTH - 1));

`ifdef CIRCUITO_SEQUENCIA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] espera_cnt;
    logic          flag_timeout;

    assign expirou = (espera_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counter is held at 0 outside ESPERA so every entry starts fresh
    always_ff @(posedge clock) begin
        if (!reset) begin
            espera_cnt   <= '0;
            flag_timeout <= 1'b0;
        end else begin
            if (estado == ESPERA)
                espera_cnt <= espera_cnt + TW'(1);
            else
                espera_cnt <= '0;

            if (estado == PREPARACAO)
                flag_timeout <= 1'b0;
            else if (estado == ESPERA && !pulso && expirou)
                flag_timeout <= 1'b1;
        end
    end

    assign db_timeout = flag_timeout && (estado == FIM_ERRO);
`else
    assign expirou    = 1'b0;
    assign db_timeout = 1'b0;
`endif

    always_comb begin
        estado_prox = estado;
        case (estado)
            INICIAL:
                if (iniciar) estado_prox = PREPARACAO;
            PREPARACAO:
                estado_prox = ESPERA;
            ESPERA:
                if (pulso)
                    estado_prox = REGISTRA;
                else if (expirou)
                    estado_prox = FIM_ERRO;
            REGISTRA:
                estado_prox = COMPARA;
            COMPARA:
                if (!igual)
                    estado_prox = FIM_ERRO;
                else if (ultimo)
                    estado_prox = FIM_ACERTO;
                else
                    estado_prox = PROXIMO;
            PROXIMO:
                estado_prox = ESPERA;
            FIM_ACERTO, FIM_ERRO:
                if (iniciar) estado_prox = PREPARACAO;
            default:
                estado_prox = INICIAL;
        endcase
    end

    // Status flags are registered from the next state so they align with estado
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado     <= INICIAL;
            contagem   <= '0;
            chaves_reg <= '0;
            jogada_ant <= 1'b0;
            pulso      <= 1'b0;
            pronto     <= 1'b0;
            acertou    <= 1'b0;
            errou      <= 1'b0;
        end else begin
            estado     <= estado_prox;
            jogada_ant <= jogada;
            pulso      <= jogada && !jogada_ant;
            pronto     <= (estado_prox == FIM_ACERTO) ||
                          (estado_prox == FIM_ERRO);
            acertou    <= (estado_prox == FIM_ACERTO);
            errou      <= (estado_prox == FIM_ERRO);

            if (estado == PREPARACAO) begin
                contagem   <= '0;
                chaves_reg <= '0;
            end
            if (estado == REGISTRA)
                chaves_reg <= chaves;
            if (estado == PROXIMO)
                contagem <= contagem + ADDR_W'(1);
        end
    end

    assign db_igual    = igual;
    assign db_jogada   = pulso;
    assign db_contagem = contagem;
    assign db_memoria  = rom_dado;
    assign db_chaves   = chaves_reg;
    assign db_estado   = estado;

endmodule

// File: tb/tb_circuito_sequencia_param.sv
// Directed bench for circuito_sequencia_param with a cycle-level game model.
// Timeout scenario follows CIRCUITO_SEQUENCIA_TIMEOUT_EN.
module tb_circuito_sequencia_param;

    localparam int DW = 4;
    localparam int DP = 4;
    localparam int AW = 2;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iniciar = 1'b0;
    logic          jogada = 1'b0;
    logic [DW-1:0] chaves = '0;
    logic          pronto, acertou, errou;
    logic          db_igual, db_jogada, db_timeout;
    logic [AW-1:0] db_contagem;
    logic [DW-1:0] db_memoria, db_chaves;
    logic [3:0]    db_estado;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    circuito_sequencia_param #(
        .DATA_W(DW), .DEPTH(DP), .MEM_FILE(""), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada(jogada), .chaves(chaves),
        .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_igual(db_igual), .db_jogada(db_jogada),
        .db_timeout(db_timeout), .db_contagem(db_contagem),
        .db_memoria(db_memoria), .db_chaves(db_chaves),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

`ifdef CIRCUITO_SEQUENCIA_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    // Game model: phase, address, latched play, edge history, wait length
    int m_st = 0;
    int m_cnt = 0;
    int m_reg = 0;
    bit m_hist = 0;
    bit m_pulse = 0;
    int m_wait = 0;
    bit m_tflag = 0;

    function automatic int rom_of(int a);
        return a % 16;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_st <= 0; m_cnt <= 0; m_reg <= 0;
            m_hist <= 0; m_pulse <= 0; m_wait <= 0; m_tflag <= 0;
        end else begin
            m_hist  <= jogada;
            m_pulse <= jogada && !m_hist;
            m_wait  <= (m_st == 2) ? m_wait + 1 : 0;
            if (m_st == 0) begin
                if (iniciar) m_st <= 1;
            end else if (m_st == 1) begin
                m_cnt <= 0; m_reg <= 0; m_tflag <= 0; m_st <= 2;
            end else if (m_st == 2) begin
                if (m_pulse) m_st <= 4;
                else if (TO_ON && m_wait == TO - 1) begin
                    m_st <= 14; m_tflag <= 1;
                end
            end else if (m_st == 4) begin
                m_reg <= int'(chaves); m_st <= 5;
            end else if (m_st == 5) begin
                if (m_reg != rom_of(m_cnt)) m_st <= 14;
                else if (m_cnt == DP - 1) m_st <= 10;
                else m_st <= 6;
            end else if (m_st == 6) begin
                m_cnt <= m_cnt + 1; m_st <= 2;
            end else if (iniciar) begin
                m_st <= 1;
            end
        end
    end

    function automatic logic [21:0] model_vec();
        logic [21:0] v;
        v[21]    = (m_st == 10) || (m_st == 14);
        v[20]    = (m_st == 10);
        v[19]    = (m_st == 14);
        v[18]    = (m_reg == rom_of(m_cnt));
        v[17]    = m_pulse;
        v[16]    = m_tflag && (m_st == 14);
        v[15:14] = AW'(m_cnt);
        v[13:10] = DW'(rom_of(m_cnt));
        v[9:6]   = DW'(m_reg);
        v[5:2]   = 4'(m_st);
        v[1:0]   = 2'b00;
        return v;
    endfunction

    wire [21:0] dut_vec = {pronto, acertou, errou, db_igual, db_jogada,
                           db_timeout, db_contagem, db_memoria, db_chaves,
                           db_estado, 2'b00};

    always @(negedge clock) begin
        if (checking) begin
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_err++;
                $display("FAIL cycle_model t=%0t got %h expected %h",
                         $time, dut_vec, model_vec());
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic start();
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        cycles(2);
    endtask

    task automatic play(logic [DW-1:0] v);
        @(negedge clock); chaves = v; jogada = 1'b1;
        @(negedge clock); jogada = 1'b0;
        cycles(5);
    endtask

    initial begin
        reset = 1'b0;
        cycles(2);
        checking = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_estado", 32'(db_estado), 32'h0);
        chk("rst_flags", {29'd0, pronto, acertou, errou}, 32'h0);
        chk("rst_cnt", 32'(db_contagem), 32'h0);
        chk("rst_reg", 32'(db_chaves), 32'h0);

        start();
        chk("espera", 32'(db_estado), 32'h2);
        for (int i = 0; i < DP; i++) begin
            play(DW'(i));
            if (i < DP - 1)
                chk("cnt_step", 32'(db_contagem), 32'(i + 1));
        end
        chk("ok_estado", 32'(db_estado), 32'hA);
        chk("ok_flags", {29'd0, pronto, acertou, errou}, 32'h6);
        chk("ok_cnt", 32'(db_contagem), 32'h3);

        start();
        play(4'd0);
        play(4'd1);
        play(4'd7);
        chk("err_estado", 32'(db_estado), 32'hE);
        chk("err_cnt", 32'(db_contagem), 32'h2);
        chk("err_reg", 32'(db_chaves), 32'h7);
        chk("err_mem", 32'(db_memoria), 32'h2);
        chk("err_igual", 32'(db_igual), 32'h0);
        chk("err_flags", {29'd0, pronto, acertou, errou}, 32'h5);

        start();
        @(negedge clock); chaves = 4'd0; jogada = 1'b1;
        cycles(20);
        jogada = 1'b0;
        cycles(3);
        chk("held_cnt", 32'(db_contagem), 32'h1);
        chk("held_estado", 32'(db_estado), 32'h2);

        @(negedge clock); chaves = 4'd1; jogada = 1'b1;
        @(negedge clock); jogada = 1'b0;
        cycles(2);
        chk("mid_compara", 32'(db_estado), 32'h5);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_estado", 32'(db_estado), 32'h0);
        chk("mid_rst_cnt", 32'(db_contagem), 32'h0);
        chk("mid_rst_flags", {28'd0, pronto, acertou, errou, db_timeout},
            32'h0);
        reset = 1'b1;
        cycles(2);

        start();
        if (TO_ON) begin
            cycles(20);
            chk("to_estado", 32'(db_estado), 32'hE);
            chk("to_flag", 32'(db_timeout), 32'h1);
            chk("to_errou", 32'(errou), 32'h1);
        end else begin
            cycles(100);
            chk("wait_estado", 32'(db_estado), 32'h2);
            chk("wait_flag", 32'(db_timeout), 32'h0);
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
